// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU job sequencer: phase encoding, Avalon region offsets and
// the default systolic array dimension.
package tpu_ctrl_pkg;

  localparam int unsigned DefaultDim = 16;

  localparam logic [1:0] RegionControl = 2'b00;
  localparam logic [1:0] RegionWeight  = 2'b01;
  localparam logic [1:0] RegionInput   = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StFillW,
    StLoadW,
    StFillD,
    StMult,
    StDrain,
    StDone
  } seq_state_e;

  function automatic logic is_busy_state(seq_state_e s);
    return (s == StFillW) || (s == StLoadW) || (s == StFillD) || (s == StMult) ||
           (s == StDrain);
  endfunction

endpackage

// File: rtl/tpu_step_counter.sv
// Per-phase step counter: synchronous clear, count enable, terminal flag at limit_i - 1.
module tpu_step_counter #(
  parameter int unsigned Width = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] count_o,
  output logic             term_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign count_o = cnt_q;
  assign term_o  = (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/tpu_sequencer.sv
// Runs one matrix-multiply job on the systolic array: weight fill, weight load, data fill,
// multiply and result drain, with fixed phase lengths derived from the array dimension.
module tpu_sequencer
  import tpu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH_HEIGHT = DefaultDim,
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_w_in,
  input  logic [ADDR_WIDTH-1:0] base_d_in,
  input  logic [ADDR_WIDTH-1:0] base_o_in,
  output logic                  wr_en_fifo,
  output logic                  fifo_sel,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  load_en_weight,
  output logic                  mult_en,
  output logic                  wr_en_output,
  output logic [ADDR_WIDTH-1:0] wr_addr_output,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int unsigned CntW = $clog2(2 * WIDTH_HEIGHT) + 1;

  seq_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_w_q, base_d_q, base_o_q;
  logic                  wr_en_fifo_q, fifo_sel_q, load_en_weight_q, mult_en_q;
  logic                  wr_en_output_q, busy_q, done_q, overrun_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, wr_addr_output_q;

  logic            cnt_clr, cnt_term;
  logic [CntW-1:0] cnt, cnt_limit, cnt_next;
  logic [ADDR_WIDTH-1:0] step_off;
  logic            start_accept;

  tpu_step_counter #(
    .Width (CntW)
  ) u_step_counter (
    .clk_i   (clk),
    .rst_ni  (reset),
    .clr_i   (cnt_clr),
    .en_i    (1'b1),
    .limit_i (cnt_limit),
    .count_o (cnt),
    .term_o  (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFillW;
      StFillW: if (cnt_term) state_d = StLoadW;
      StLoadW: if (cnt_term) state_d = StFillD;
      StFillD: if (cnt_term) state_d = StMult;
      StMult:  if (cnt_term) state_d = StDrain;
      StDrain: if (cnt_term) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
    end
  end

  assign start_accept = (state_q == StIdle) && start && !abort;
  assign cnt_clr      = (state_d != state_q);
  assign cnt_limit    = (state_q == StMult) ? CntW'(2 * WIDTH_HEIGHT) : CntW'(WIDTH_HEIGHT);
  // Offset the registered addresses by the step index the next state will hold.
  assign cnt_next     = cnt_clr ? '0 : cnt + 1'b1;
  assign step_off     = ADDR_WIDTH'(cnt_next);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StIdle;
      base_w_q         <= '0;
      base_d_q         <= '0;
      base_o_q         <= '0;
      wr_en_fifo_q     <= 1'b0;
      fifo_sel_q       <= 1'b0;
      load_en_weight_q <= 1'b0;
      mult_en_q        <= 1'b0;
      wr_en_output_q   <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      overrun_q        <= 1'b0;
      rd_addr_q        <= '0;
      wr_addr_output_q <= '0;
    end else begin
      state_q          <= state_d;
      wr_en_fifo_q     <= (state_d == StFillW) || (state_d == StFillD);
      fifo_sel_q       <= (state_d == StFillD);
      load_en_weight_q <= (state_d == StLoadW);
      mult_en_q        <= (state_d == StMult);
      wr_en_output_q   <= (state_d == StDrain);
      busy_q           <= is_busy_state(state_d);
      done_q           <= (state_d == StDone);

      if (start_accept) begin
        base_w_q <= base_w_in;
        base_d_q <= base_d_in;
        base_o_q <= base_o_in;
      end

      if (start_accept) begin
        overrun_q <= 1'b0;
      end else if (start && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end

      // The first weight address comes straight from the port; bases latch on this same edge.
      if (state_d == StFillW) begin
        rd_addr_q <= (state_q == StIdle) ? base_w_in : base_w_q + step_off;
      end else if (state_d == StFillD) begin
        rd_addr_q <= base_d_q + step_off;
      end

      if (state_d == StDrain) begin
        wr_addr_output_q <= base_o_q + step_off;
      end
    end
  end

  assign wr_en_fifo     = wr_en_fifo_q;
  assign fifo_sel       = fifo_sel_q;
  assign rd_addr        = rd_addr_q;
  assign load_en_weight = load_en_weight_q;
  assign mult_en        = mult_en_q;
  assign wr_en_output   = wr_en_output_q;
  assign wr_addr_output = wr_addr_output_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign overrun        = overrun_q;

endmodule
